fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the synchronous instruction ROM and the datapath.

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting between a synchronous instruction ROM and the
// datapath. It owns the program counter, drives the ROM word address plus a
// hold line (the ROM keeps its address register while hold is high), and
// presents each fetched instruction with its byte PC and a valid flag.
// Redirects (branch/jal/jalr), stalls and a HALT opcode are handled here, and a
// saturating retired-instruction counter is maintained.
//
// Ports
//   clk            in   1       system clock, all state on posedge
//   reset          in   1       synchronous, active-high
//   stall_i        in   1       datapath not ready; hold current instruction
//   redirect_i     in   1       take redirect_pc_i as next PC
//   redirect_pc_i  in   32      redirect byte target, bits [1:0] forced to 0
//   imem_addr_o    out  ADDR_W  ROM word address (combinational)
//   imem_hold_o    out  1       ROM address-register hold (combinational)
//   imem_rdata_i   in   32      ROM data, valid 1 cycle after address capture
//   instr_o        out  32      current instruction (= imem_rdata_i)
//   pc_o           out  32      byte PC of instr_o
//   instr_valid_o  out  1       instr_o / pc_o meaningful
//   halted_o       out  1       HALT reached, sticky until reset
//   instr_count_o  out  32      retired instructions (saturating)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          ADDR_W      = 6,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [6:0]  HALT_OPCODE = 7'h7F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_hold_o,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic              instr_valid_o,
  output logic              halted_o,
  output logic [31:0]       instr_count_o
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;       // next byte PC to issue to the ROM
  logic [31:0] fetch_pc_next;
  logic [31:0] pc_q;           // byte PC of the word now on imem_rdata_i
  logic [31:0] pc_q_next;
  logic [31:0] count;
  logic [31:0] count_next;
  logic        count_inc;

  logic [31:0] target;         // word-aligned redirect target
  logic [31:0] issue_pc;       // byte PC whose word address goes to the ROM
  logic        hold;
  logic        halt_det;

  assign target   = {redirect_pc_i[31:2], 2'b00};
  assign halt_det = (state == S_RUN) && (imem_rdata_i[6:0] == HALT_OPCODE);

  // ---------------------------------------------------------------------------
  // Next-state / issue logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    pc_q_next     = pc_q;
    count_inc     = 1'b0;
    issue_pc      = fetch_pc;
    hold          = 1'b0;

    unique case (state)
      S_FILL: begin
        // Prime the ROM pipeline; stall and redirect have nothing to act on yet.
        pc_q_next     = fetch_pc;
        fetch_pc_next = fetch_pc + 32'd4;
        state_next    = S_RUN;
      end

      S_RUN: begin
        if (halt_det) begin
          // HALT retires and wins over anything the datapath asks for.
          hold       = 1'b1;
          count_inc  = 1'b1;
          state_next = S_HALT;
        end else if (redirect_i) begin
          // Issue the target directly so it is on the ROM output next cycle.
          issue_pc      = target;
          pc_q_next     = target;
          fetch_pc_next = target + 32'd4;
          // A simultaneous stall means the current instruction did not retire.
          count_inc     = !stall_i;
        end else if (stall_i) begin
          hold = 1'b1;
        end else begin
          pc_q_next     = fetch_pc;
          fetch_pc_next = fetch_pc + 32'd4;
          count_inc     = 1'b1;
        end
      end

      S_HALT: begin
        hold = 1'b1;
      end

      default: begin
        state_next = S_FILL;
      end
    endcase
  end

  assign count_next = (count_inc && (count != COUNT_MAX)) ? count + 32'd1 : count;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FILL;
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      count    <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      pc_q     <= pc_q_next;
      count    <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Reset is synchronous, so the registers may still hold pre-reset values in
  // the reset cycle itself; gating with reset keeps the outputs quiet then too.
  assign imem_addr_o   = reset ? RESET_PC[ADDR_W+1:2] : issue_pc[ADDR_W+1:2];
  assign imem_hold_o   = hold && !reset;
  assign instr_o       = imem_rdata_i;
  assign pc_o          = pc_q;
  assign instr_valid_o = (state == S_RUN) && !reset;
  assign halted_o      = (state == S_HALT) && !reset;
  assign instr_count_o = reset ? 32'd0 : count;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with a behavioural synchronous ROM (address
// register honouring imem_hold_o). ROM word i holds {i, 7'h13} so every word
// is distinct and none matches the HALT opcode unless a test plants one.
// Inputs change 1 ns after posedge; outputs are sampled 1 ns after that.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_hold_o;
  logic [31:0]       imem_rdata_i;
  logic [31:0]       instr_o;
  logic [31:0]       pc_o;
  logic              instr_valid_o;
  logic              halted_o;
  logic [31:0]       instr_count_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rom_addr_q;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (!imem_hold_o) rom_addr_q <= imem_addr_o;
  end
  assign imem_rdata_i = mem[rom_addr_q];

  fetch_unit #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (32'h0),
    .HALT_OPCODE(7'h7F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_hold_o  (imem_hold_o),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .instr_valid_o(instr_valid_o),
    .halted_o     (halted_o),
    .instr_count_o(instr_count_o)
  );

  function automatic logic [31:0] rom_word(input int i);
    return (32'(i) << 7) | 32'h13;
  endfunction

  task automatic load_rom();
    for (int i = 0; i < DEPTH; i++) mem[i] = rom_word(i);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, then release; returns in the FILL cycle.
  task automatic do_reset();
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    cyc();
    cyc();
    checks++;
    if (instr_valid_o !== 1'b0 || halted_o !== 1'b0 || imem_hold_o !== 1'b0 ||
        instr_count_o !== 32'd0 || pc_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b halted=%b hold=%b count=%0d pc=%h expected 0 0 0 0 0",
               instr_valid_o, halted_o, imem_hold_o, instr_count_o, pc_o);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || imem_addr_o !== 6'd0) begin
      failures++;
      $display("FAIL fill_cycle: valid=%b addr=%0d expected valid=0 addr=0", instr_valid_o, imem_addr_o);
    end
    // Sequential fetch: pc 0,4,8 with addr 1,2,3 and count trailing by one.
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'(4 * k) || imem_addr_o !== 6'(k + 1) ||
          instr_count_o !== 32'(k) || instr_o !== rom_word(k)) begin
        failures++;
        $display("FAIL seq_%0d: valid=%b pc=%h addr=%0d count=%0d instr=%h expected 1 %h %0d %0d %h",
                 k, instr_valid_o, pc_o, imem_addr_o, instr_count_o, instr_o,
                 32'(4 * k), k + 1, k, rom_word(k));
      end
    end
  endtask

  // Entered with pc_o=8, count=2.
  task automatic test_stall();
    stall_i = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (imem_hold_o !== 1'b1 || pc_o !== 32'h8 || instr_o !== rom_word(2) ||
          instr_count_o !== 32'd2 || instr_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL stall_%0d: hold=%b pc=%h instr=%h count=%0d valid=%b expected 1 8 %h 2 1",
                 s, imem_hold_o, pc_o, instr_o, instr_count_o, instr_valid_o, rom_word(2));
      end
      cyc();
    end
    stall_i = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h8 || imem_hold_o !== 1'b0 || imem_addr_o !== 6'd3 || instr_count_o !== 32'd2) begin
      failures++;
      $display("FAIL stall_release: pc=%h hold=%b addr=%0d count=%0d expected 8 0 3 2",
               pc_o, imem_hold_o, imem_addr_o, instr_count_o);
    end
    cyc();
    checks++;
    if (pc_o !== 32'hC || instr_o !== rom_word(3) || instr_count_o !== 32'd3) begin
      failures++;
      $display("FAIL stall_after: pc=%h instr=%h count=%0d expected c %h 3",
               pc_o, instr_o, instr_count_o, rom_word(3));
    end
  endtask

  task automatic test_redirect();
    do_reset();
    cyc(); cyc(); cyc();                 // pc_o 0, 4, 8
    redirect_i = 1'b1; redirect_pc_i = 32'h17;
    #1;
    checks++;
    if (imem_addr_o !== 6'd5 || imem_hold_o !== 1'b0 || pc_o !== 32'h8) begin
      failures++;
      $display("FAIL redirect_addr: addr=%0d hold=%b pc=%h expected 5 0 8", imem_addr_o, imem_hold_o, pc_o);
    end
    cyc();
    redirect_i = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h14 || instr_o !== rom_word(5) || instr_valid_o !== 1'b1 || instr_count_o !== 32'd3) begin
      failures++;
      $display("FAIL redirect_target: pc=%h instr=%h valid=%b count=%0d expected 14 %h 1 3",
               pc_o, instr_o, instr_valid_o, instr_count_o, rom_word(5));
    end
    cyc();
    checks++;
    if (pc_o !== 32'h18 || instr_o !== rom_word(6) || instr_count_o !== 32'd4) begin
      failures++;
      $display("FAIL redirect_next: pc=%h instr=%h count=%0d expected 18 %h 4",
               pc_o, instr_o, instr_count_o, rom_word(6));
    end
  endtask

  // Entered with pc_o=0x18, count=4.
  task automatic test_redirect_stall();
    redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h42;
    #1;
    checks++;
    if (imem_addr_o !== 6'd16 || imem_hold_o !== 1'b0) begin
      failures++;
      $display("FAIL redir_stall_addr: addr=%0d hold=%b expected 16 0", imem_addr_o, imem_hold_o);
    end
    cyc();
    redirect_i = 1'b0; stall_i = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h40 || instr_o !== rom_word(16) || instr_count_o !== 32'd4) begin
      failures++;
      $display("FAIL redir_stall_target: pc=%h instr=%h count=%0d expected 40 %h 4",
               pc_o, instr_o, instr_count_o, rom_word(16));
    end
    cyc();
    checks++;
    if (pc_o !== 32'h44 || instr_count_o !== 32'd5) begin
      failures++;
      $display("FAIL redir_stall_next: pc=%h count=%0d expected 44 5", pc_o, instr_count_o);
    end
  endtask

  task automatic test_halt();
    mem[4] = 32'h0000_007F;
    do_reset();
    cyc(); cyc(); cyc(); cyc(); cyc();   // pc_o 0, 4, 8, c, 10
    checks++;
    if (pc_o !== 32'h10 || instr_o !== 32'h7F || instr_count_o !== 32'd4) begin
      failures++;
      $display("FAIL halt_fetch: pc=%h instr=%h count=%0d expected 10 7f 4", pc_o, instr_o, instr_count_o);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    #1;
    checks++;
    if (imem_hold_o !== 1'b1) begin
      failures++;
      $display("FAIL halt_hold: hold=%b expected 1", imem_hold_o);
    end
    cyc();
    checks++;
    if (halted_o !== 1'b1 || instr_valid_o !== 1'b0 || pc_o !== 32'h10 || instr_count_o !== 32'd5) begin
      failures++;
      $display("FAIL halt_enter: halted=%b valid=%b pc=%h count=%0d expected 1 0 10 5",
               halted_o, instr_valid_o, pc_o, instr_count_o);
    end
    for (int i = 0; i < 20; i++) begin
      stall_i    = i[0];
      redirect_i = i[1];
      cyc();
      checks++;
      if (halted_o !== 1'b1 || imem_hold_o !== 1'b1 || pc_o !== 32'h10 ||
          instr_count_o !== 32'd5 || instr_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL halt_frozen_%0d: halted=%b hold=%b pc=%h count=%0d valid=%b expected 1 1 10 5 0",
                 i, halted_o, imem_hold_o, pc_o, instr_count_o, instr_valid_o);
      end
    end
  endtask

  task automatic test_reset_halted();
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
    cyc();
    checks++;
    if (halted_o !== 1'b0 || pc_o !== 32'h0 || instr_count_o !== 32'd0 ||
        instr_valid_o !== 1'b0 || imem_hold_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_halted: halted=%b pc=%h count=%0d valid=%b hold=%b expected 0 0 0 0 0",
               halted_o, pc_o, instr_count_o, instr_valid_o, imem_hold_o);
    end
    mem[4] = rom_word(4);
    reset = 1'b0;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || imem_addr_o !== 6'd0 || halted_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_halted_fill: valid=%b addr=%0d halted=%b expected 0 0 0",
               instr_valid_o, imem_addr_o, halted_o);
    end
    cyc();
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== rom_word(0)) begin
      failures++;
      $display("FAIL reset_halted_run: valid=%b pc=%h instr=%h expected 1 0 %h",
               instr_valid_o, pc_o, instr_o, rom_word(0));
    end
  endtask

  task automatic test_reset_stalled();
    do_reset();
    cyc(); cyc(); cyc();                 // pc_o 0, 4, 8
    stall_i = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if (pc_o !== 32'h0 || instr_count_o !== 32'd0 || instr_valid_o !== 1'b0 ||
        imem_hold_o !== 1'b0 || halted_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_stalled: pc=%h count=%0d valid=%b hold=%b halted=%b expected 0 0 0 0 0",
               pc_o, instr_count_o, instr_valid_o, imem_hold_o, halted_o);
    end
    reset = 1'b0;                        // stall stays high: FILL ignores it
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || imem_addr_o !== 6'd0 || imem_hold_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_stalled_fill: valid=%b addr=%0d hold=%b expected 0 0 0",
               instr_valid_o, imem_addr_o, imem_hold_o);
    end
    cyc();
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || imem_hold_o !== 1'b1 || instr_o !== rom_word(0)) begin
      failures++;
      $display("FAIL reset_stalled_run: valid=%b pc=%h hold=%b instr=%h expected 1 0 1 %h",
               instr_valid_o, pc_o, imem_hold_o, instr_o, rom_word(0));
    end
    stall_i = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 64; i++) cyc();  // pc_o reaches 0xfc
    checks++;
    if (pc_o !== 32'hFC || imem_addr_o !== 6'd0 || instr_count_o !== 32'd63 || instr_o !== rom_word(63)) begin
      failures++;
      $display("FAIL wrap_last: pc=%h addr=%0d count=%0d instr=%h expected fc 0 63 %h",
               pc_o, imem_addr_o, instr_count_o, instr_o, rom_word(63));
    end
    cyc();
    checks++;
    if (pc_o !== 32'h100 || instr_o !== rom_word(0) || instr_count_o !== 32'd64 || imem_addr_o !== 6'd1) begin
      failures++;
      $display("FAIL wrap_first: pc=%h instr=%h count=%0d addr=%0d expected 100 %h 64 1",
               pc_o, instr_o, instr_count_o, imem_addr_o, rom_word(0));
    end
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    load_rom();
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_halt();
    test_reset_halted();
    test_reset_stalled();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
